rtc_bus_ctrl: RTL and testbench
===============================

// Module: rtc_bus_ctrl
// PURPOSE
//  Sequences one read or write transaction on the RTC's multiplexed address/data bus.
//  A transaction is an address phase followed by a data phase.
//  Drives CS_n/RD_n/WR_n/A_D and the AD mux select En_AD. Presents the value to drive on
//  AD_escritura and captures read data from the bus. Sits between the user/time-keeping
//  FSM and the AD mux / tristate pad.
// PARAMETERS
//  largo    8  width of address/data bus
//  T_FASE   4  clock cycles per pulse phase (>=1); counter width $clog2(T_FASE+1)
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  reset_n        in   1      synchronous, active-low reset
//  start          in   1      request a transaction; sampled only in IDLE
//  rw             in   1      1 = write, 0 = read; latched with start
//  dir            in   largo  RTC register address; latched with start
//  dato_escritura in   largo  write data; latched with start
//  AD_in          in   largo  value read back from the AD pad
//  AD_escritura   out  largo  value to drive on the bus (address or write data)
//  En_AD          out  1      AD mux select: 1 = drive AD_escritura, 0 = read path
//  bus_oe         out  1      pad tristate enable, 1 = drive bus
//  CS_n,RD_n,WR_n out  1      RTC strobes, active low
//  A_D            out  1      0 = address phase, 1 = data phase
//  dato_lectura   out  largo  last captured read data, held until next read
//  ocupado        out  1      1 while a transaction is in progress
//  listo          out  1      one-cycle completion pulse
// BEHAVIOUR
//  Reset (reset_n=0 at an edge) values:
//   - state IDLE; CS_n=RD_n=WR_n=1; A_D=1.
//   - En_AD=0, bus_oe=0, AD_escritura=0, dato_lectura=0, ocupado=0, listo=0.
//  Outputs are all registered.
//  States: IDLE -> DIR_LO -> DIR_HI -> DATO_LO -> DATO_HI -> IDLE.
//   Each non-IDLE state lasts exactly T_FASE cycles.
//  IDLE:
//   - start=1 latches rw/dir/dato_escritura; next cycle enters DIR_LO, ocupado=1.
//  DIR_LO:  CS_n=0, WR_n=0, A_D=0, En_AD=1, bus_oe=1, AD_escritura=dir.
//  DIR_HI:  CS_n=1, WR_n=1, A_D=0; address still driven (hold).
//  DATO_LO, write (rw=1):
//   - CS_n=0, WR_n=0, A_D=1, En_AD=1, bus_oe=1, AD_escritura=dato.
//  DATO_LO, read (rw=0):
//   - CS_n=0, RD_n=0, A_D=1, En_AD=0, bus_oe=0.
//   - AD_in captured into dato_lectura at the edge ending the last DATO_LO cycle.
//  DATO_HI:
//   - CS_n=RD_n=WR_n=1, A_D=1.
//   - Write keeps driving data (hold); read keeps bus released.
//  On leaving DATO_HI: IDLE, ocupado=0, listo=1 for exactly that first IDLE cycle;
//   bus_oe=0, En_AD=0.
//  Latency: start sampled at edge k -> listo high in cycle k+4*T_FASE+1.
//  Boundary conditions:
//   - start while ocupado=1: ignored, latched operands unchanged.
//   - start during the listo cycle: accepted (state is IDLE); back-to-back allowed.
//   - rw/dir/dato changing mid-transaction: no effect.
//   - reset_n=0 mid-transaction: aborts at that edge to reset values; no listo;
//     dato_lectura cleared.
//   - Writes never modify dato_lectura.
//   - RD_n and WR_n are never low in the same cycle.
//   - bus_oe=0 whenever RD_n=0.
// TESTING (T_FASE=2)
//  1. Reset held 3 cycles, then released, no start -> all outputs at reset values,
//     ocupado=0.
//  2. Write dir=8'h21, dato=8'h45 -> AD_escritura=21 with A_D=0/WR_n=0 for 2 cycles,
//     then 2 hold cycles; AD_escritura=45 with A_D=1/WR_n=0 for 2 cycles;
//     listo at k+9.
//  3. Read dir=8'h22, AD_in=8'h37 in DATO_LO -> RD_n=0, bus_oe=0, En_AD=0;
//     dato_lectura=37 and listo=1 at k+9.
//  4. start pulsed at k+3 of an active write -> ignored; exactly one listo pulse.
//  5. reset_n=0 during DATO_LO of a read -> next cycle CS_n=RD_n=1, bus_oe=0,
//     dato_lectura=0, no listo.
//  6. Write then read with start high in the listo cycle -> second transaction's DIR_LO
//     begins next cycle; the two listo pulses are 9 cycles apart.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences one read or write on the RTC multiplexed AD bus.
// Each transaction is an address phase (DIR_LO/DIR_HI) followed by a data
// phase (DATO_LO/DATO_HI). Each phase part lasts T_FASE clock cycles.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start, rw           request (sampled in IDLE), 1 = write / 0 = read
//   dir, dato_escritura register address and write data, latched with start
//   AD_in               value read back from the AD pad
//   AD_escritura        value to drive on the bus (address or write data)
//   En_AD, bus_oe       AD mux select and pad tristate enable
//   CS_n, RD_n, WR_n    RTC strobes, active low
//   A_D                 0 = address phase, 1 = data phase
//   dato_lectura        last captured read data
//   ocupado, listo      busy flag and one-cycle completion pulse
module rtc_bus_ctrl #(
  parameter int unsigned largo  = 8,
  parameter int unsigned T_FASE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rw,
  input  logic [largo-1:0] dir,
  input  logic [largo-1:0] dato_escritura,
  input  logic [largo-1:0] AD_in,
  output logic [largo-1:0] AD_escritura,
  output logic             En_AD,
  output logic             bus_oe,
  output logic             CS_n,
  output logic             RD_n,
  output logic             WR_n,
  output logic             A_D,
  output logic [largo-1:0] dato_lectura,
  output logic             ocupado,
  output logic             listo
);

  localparam int unsigned CW = $clog2(T_FASE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_FASE - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DIR_LO  = 3'd1;
  localparam logic [2:0] S_DIR_HI  = 3'd2;
  localparam logic [2:0] S_DATO_LO = 3'd3;
  localparam logic [2:0] S_DATO_HI = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [largo-1:0] dir_q, dir_d;
  logic [largo-1:0] dato_q, dato_d;
  logic [largo-1:0] dl_q, dl_d;
  logic [largo-1:0] ade_q, ade_d;
  logic             en_q, en_d;
  logic             oe_q, oe_d;
  logic             cs_q, cs_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             ad_q, ad_d;
  logic             ocup_q, ocup_d;
  logic             listo_q, listo_d;
  logic             phase_end;

  // Next state, phase counter, operand latch and read capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    dir_d     = dir_q;
    dato_d    = dato_q;
    dl_d      = dl_q;
    phase_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DIR_LO;
          rw_d    = rw;
          dir_d   = dir;
          dato_d  = dato_escritura;
        end
      end
      S_DIR_LO:  if (phase_end) state_d = S_DIR_HI;
      S_DIR_HI:  if (phase_end) state_d = S_DATO_LO;
      S_DATO_LO: begin
        if (phase_end) begin
          state_d = S_DATO_HI;
          // Capture on the edge that ends the last strobe-low cycle.
          if (!rw_q) dl_d = AD_in;
        end
      end
      S_DATO_HI: if (phase_end) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (phase_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output values for the state being entered, so the registered outputs
  // line up with the state register.
  always_comb begin
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    ad_d    = 1'b1;
    en_d    = 1'b0;
    oe_d    = 1'b0;
    ade_d   = ade_q;
    ocup_d  = (state_d != S_IDLE);
    listo_d = (state_q == S_DATO_HI) && (state_d == S_IDLE);

    case (state_d)
      S_DIR_LO: begin
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        ad_d  = 1'b0;
        en_d  = 1'b1;
        oe_d  = 1'b1;
        ade_d = dir_d;
      end
      S_DIR_HI: begin
        ad_d  = 1'b0;
        en_d  = 1'b1;
        oe_d  = 1'b1;
        ade_d = dir_d;
      end
      S_DATO_LO: begin
        cs_d = 1'b0;
        if (rw_d) begin
          wr_d  = 1'b0;
          en_d  = 1'b1;
          oe_d  = 1'b1;
          ade_d = dato_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      S_DATO_HI: begin
        if (rw_d) begin
          en_d  = 1'b1;
          oe_d  = 1'b1;
          ade_d = dato_d;
        end
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      dir_q   <= '0;
      dato_q  <= '0;
      dl_q    <= '0;
      ade_q   <= '0;
      en_q    <= 1'b0;
      oe_q    <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b1;
      ocup_q  <= 1'b0;
      listo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dir_q   <= dir_d;
      dato_q  <= dato_d;
      dl_q    <= dl_d;
      ade_q   <= ade_d;
      en_q    <= en_d;
      oe_q    <= oe_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      ocup_q  <= ocup_d;
      listo_q <= listo_d;
    end
  end

  assign AD_escritura = ade_q;
  assign En_AD        = en_q;
  assign bus_oe       = oe_q;
  assign CS_n         = cs_q;
  assign RD_n         = rd_q;
  assign WR_n         = wr_q;
  assign A_D          = ad_q;
  assign dato_lectura = dl_q;
  assign ocupado      = ocup_q;
  assign listo        = listo_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed bench for rtc_bus_ctrl with T_FASE=2.
// Completion events (cycle and read data) are queued when a transaction is
// started and checked when listo is observed.
module tb_rtc_bus_ctrl;

  localparam int unsigned LARGO = 8;
  localparam int unsigned TF    = 2;
  localparam int          LAT   = 4 * TF;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             rw;
  logic [LARGO-1:0] dir;
  logic [LARGO-1:0] dato_escritura;
  logic [LARGO-1:0] AD_in;
  logic [LARGO-1:0] AD_escritura;
  logic             En_AD;
  logic             bus_oe;
  logic             CS_n;
  logic             RD_n;
  logic             WR_n;
  logic             A_D;
  logic [LARGO-1:0] dato_lectura;
  logic             ocupado;
  logic             listo;

  rtc_bus_ctrl #(.largo(LARGO), .T_FASE(TF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .rw             (rw),
    .dir            (dir),
    .dato_escritura (dato_escritura),
    .AD_in          (AD_in),
    .AD_escritura   (AD_escritura),
    .En_AD          (En_AD),
    .bus_oe         (bus_oe),
    .CS_n           (CS_n),
    .RD_n           (RD_n),
    .WR_n           (WR_n),
    .A_D            (A_D),
    .dato_lectura   (dato_lectura),
    .ocupado        (ocupado),
    .listo          (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  int             last_listo = -1;
  int             first_listo;
  int             exp_cyc_q[$];
  logic [7:0]     exp_dl_q[$];
  logic [7:0]     dl_model = 8'h00;

  // Strobe bits {CS_n,RD_n,WR_n,A_D,En_AD,bus_oe,ocupado}.
  localparam logic [6:0] P_DIR_LO  = 7'b0100111;
  localparam logic [6:0] P_DIR_HI  = 7'b1110111;
  localparam logic [6:0] P_DLO_WR  = 7'b0101111;
  localparam logic [6:0] P_DHI_WR  = 7'b1111111;
  localparam logic [6:0] P_DLO_RD  = 7'b0011001;
  localparam logic [6:0] P_DHI_RD  = 7'b1111001;
  localparam logic [6:0] P_IDLE    = 7'b1111000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1ns after the edge, check invariants and completions.
  task automatic step();
    int ec;
    logic [7:0] ed;
    @(posedge clk);
    #1;
    cyc++;
    chk("rd_wr_both_low", 32'(!RD_n && !WR_n), 32'd0);
    chk("oe_during_rd", 32'(!RD_n && bus_oe), 32'd0);
    if (listo === 1'b1) begin
      last_listo = cyc;
      if (exp_cyc_q.size() == 0) begin
        chk("listo_unexpected", 32'(listo), 32'd0);
      end else begin
        ec = exp_cyc_q.pop_front();
        ed = exp_dl_q.pop_front();
        chk("listo_cycle", 32'(cyc), 32'(ec));
        chk("listo_dato_lectura", 32'(dato_lectura), 32'(ed));
        chk("listo_not_busy", 32'(ocupado), 32'd0);
      end
    end
  endtask

  task automatic start_tx(input logic r, input logic [7:0] d, input logic [7:0] w,
                          input logic [7:0] adin);
    rw = r;
    dir = d;
    dato_escritura = w;
    AD_in = adin;
    start = 1'b1;
    exp_cyc_q.push_back(cyc + 1 + LAT);
    if (!r) dl_model = adin;
    exp_dl_q.push_back(dl_model);
    step();
    start = 1'b0;
  endtask

  task automatic strobes(input string tag, input logic [6:0] exp);
    chk(tag, 32'({CS_n, RD_n, WR_n, A_D, En_AD, bus_oe, ocupado}), 32'(exp));
  endtask

  // Checks one T_FASE-long state, ending one cycle past it.
  task automatic phase(input string tag, input logic [6:0] exp, input bit use_ade,
                       input logic [7:0] ade);
    for (int i = 0; i < int'(TF); i++) begin
      strobes(tag, exp);
      if (use_ade) chk({tag, "_ad"}, 32'(AD_escritura), 32'(ade));
      step();
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_cyc_q.size() != 0; i++) step();
    chk("done_timeout", 32'(exp_cyc_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    rw = 1'b0;
    dir = '0;
    dato_escritura = '0;
    AD_in = '0;

    // 1. reset held 3 cycles, then released idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 32'({CS_n, RD_n, WR_n, A_D, En_AD, bus_oe, ocupado, listo}), 32'h0F0);
    chk("rst_ad", 32'(AD_escritura), 32'd0);
    chk("rst_dl", 32'(dato_lectura), 32'd0);
    reset_n = 1'b1;
    step();
    step();
    chk("idle_strobes", 32'({CS_n, RD_n, WR_n, A_D, En_AD, bus_oe, ocupado, listo}), 32'h0F0);
    chk("idle_dl", 32'(dato_lectura), 32'd0);

    // 2. write 21/45
    start_tx(1'b1, 8'h21, 8'h45, 8'hEE);
    phase("wr_dir_lo", P_DIR_LO, 1'b1, 8'h21);
    phase("wr_dir_hi", P_DIR_HI, 1'b1, 8'h21);
    phase("wr_dato_lo", P_DLO_WR, 1'b1, 8'h45);
    phase("wr_dato_hi", P_DHI_WR, 1'b1, 8'h45);
    wait_done(4);
    strobes("wr_end_idle", P_IDLE);
    step();
    chk("listo_one_cycle", 32'(listo), 32'd0);

    // 3. read 22, bus returns 37
    start_tx(1'b0, 8'h22, 8'h00, 8'h37);
    phase("rd_dir_lo", P_DIR_LO, 1'b1, 8'h22);
    phase("rd_dir_hi", P_DIR_HI, 1'b1, 8'h22);
    chk("rd_dl_before", 32'(dato_lectura), 32'h00);
    phase("rd_dato_lo", P_DLO_RD, 1'b0, 8'h00);
    chk("rd_dl_captured", 32'(dato_lectura), 32'h37);
    phase("rd_dato_hi", P_DHI_RD, 1'b0, 8'h00);
    wait_done(4);
    step();

    // 4. start while busy is ignored; inputs changing mid-flight have no effect
    start_tx(1'b1, 8'hA5, 8'h5A, 8'h00);
    step();
    step();
    rw = 1'b0;
    dir = 8'hFF;
    dato_escritura = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    strobes("busy_dir_hi", P_DIR_HI);
    chk("busy_dir_hold", 32'(AD_escritura), 32'hA5);
    step();
    strobes("busy_dato_lo", P_DLO_WR);
    chk("busy_dato", 32'(AD_escritura), 32'h5A);
    wait_done(10);
    repeat (12) step();
    chk("busy_idle_after", 32'(ocupado), 32'd0);

    // 5. reset during DATO_LO of a read
    start_tx(1'b0, 8'h30, 8'h00, 8'h99);
    repeat (LAT / 2) step();
    strobes("abort_in_dato_lo", P_DLO_RD);
    reset_n = 1'b0;
    step();
    exp_cyc_q.delete();
    exp_dl_q.delete();
    dl_model = 8'h00;
    chk("abort_strobes", 32'({CS_n, RD_n, WR_n, A_D, En_AD, bus_oe, ocupado, listo}), 32'h0F0);
    chk("abort_dl", 32'(dato_lectura), 32'd0);
    reset_n = 1'b1;
    repeat (12) step();
    chk("abort_no_listo", 32'(last_listo < cyc - 12), 32'd1);

    // 6. back-to-back write then read, second start in the listo cycle
    start_tx(1'b1, 8'h11, 8'h22, 8'h00);
    wait_done(20);
    chk("b2b_listo1", 32'(listo), 32'd1);
    first_listo = last_listo;
    start_tx(1'b0, 8'h33, 8'h00, 8'h66);
    strobes("b2b_dir_lo", P_DIR_LO);
    chk("b2b_dir", 32'(AD_escritura), 32'h33);
    wait_done(20);
    chk("b2b_gap", 32'(last_listo - first_listo), 32'(LAT + 1));
    chk("b2b_dl", 32'(dato_lectura), 32'h66);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
